// File: rtl/prng_hist.sv
// rtl/prng_hist.sv - histogram checker binning the top Bbits of each prng word over Nsamp samples.
// Optional sum-of-squares readout statistic is built only when PRNG_HIST_CHI_EN is defined.
module prng_hist #(
  parameter int          Wout  = 32,
  parameter int          Bbits = 4,
  parameter int          Wcnt  = 24,
  parameter int unsigned Nsamp = 65536
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [Wout-1:0]           din,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      sat,
  output logic                      hist_valid,
  input  logic                      hist_ready,
  output logic [Bbits-1:0]          hist_bin,
  output logic [Wcnt-1:0]           hist_count,
  output logic                      hist_last,
  output logic [2*Wcnt+Bbits-1:0]   hist_sumsq
);

  localparam int               NBINS    = 2**Bbits;
  localparam int               SW       = 2*Wcnt+Bbits;
  localparam logic [Bbits-1:0] LAST_BIN = '1;
  localparam logic [31:0]      SLAST    = 32'(Nsamp - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READOUT} state_t;

  state_t           state_q;
  logic             busy_q, done_q, sat_q, valid_q;
  logic [Bbits-1:0] idx_q;
  logic [31:0]      scnt_q;
  logic             s1_v_q;
  logic [Bbits-1:0] s1_bin_q;
  logic [Wcnt-1:0]  bins_q [NBINS];

  logic [Wcnt-1:0]  cur_d, bump_d;
  logic             at_max_d;

  // Low din bits never reach a bin index.
  logic unused_din;
  assign unused_din = ^din[Wout-Bbits-1:0];

  // Stage 2 reads the array in the same cycle it writes it back, so a repeat
  // hit on the next cycle already sees the committed increment.
  always_comb begin
    cur_d    = bins_q[s1_bin_q];
    at_max_d = (cur_d == '1);
    bump_d   = at_max_d ? cur_d : cur_d + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      scnt_q   <= '0;
      s1_v_q   <= 1'b0;
      s1_bin_q <= '0;
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      s1_v_q <= 1'b0;
      if (s1_v_q) begin
        bins_q[s1_bin_q] <= bump_d;
        if (at_max_d) sat_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            sat_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        CLEAR: begin
          bins_q[idx_q] <= '0;
          idx_q         <= idx_q + 1'b1;
          if (idx_q == LAST_BIN) begin
            state_q <= ACCUM;
            scnt_q  <= '0;
          end
        end
        ACCUM: begin
          s1_v_q   <= 1'b1;
          s1_bin_q <= din[Wout-1 -: Bbits];
          scnt_q   <= scnt_q + 32'd1;
          if (scnt_q == SLAST) state_q <= DRAIN;
        end
        DRAIN: begin
          state_q <= READOUT;
          idx_q   <= '0;
          valid_q <= 1'b1;
        end
        READOUT: begin
          if (hist_ready) begin
            if (idx_q == LAST_BIN) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sat        = sat_q;
  assign hist_valid = valid_q;
  assign hist_bin   = valid_q ? idx_q : '0;
  assign hist_count = valid_q ? bins_q[idx_q] : '0;
  assign hist_last  = valid_q && (idx_q == LAST_BIN);

`ifdef PRNG_HIST_CHI_EN
  logic [SW-1:0] sumsq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sumsq_q <= '0;
    end else if (state_q == IDLE && start) begin
      sumsq_q <= '0;
    end else if (valid_q && hist_ready) begin
      sumsq_q <= sumsq_q + SW'(hist_count) * SW'(hist_count);
    end
  end

  assign hist_sumsq = sumsq_q;
`else
  assign hist_sumsq = '0;
`endif

endmodule

// File: tb/tb_prng_hist.sv
// tb/tb_prng_hist.sv - randomized scoreboard bench for prng_hist against a counting model.
module tb_prng_hist;

  localparam int W  = 32;
  localparam int B  = 3;
  localparam int WC = 4;
  localparam int N  = 20;
  localparam int NB = 1 << B;
  localparam int SW = 2*WC+B;
  localparam int CMAX = (1 << WC) - 1;
`ifdef PRNG_HIST_CHI_EN
  localparam bit CHI = 1'b1;
`else
  localparam bit CHI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          start;
  logic          busy, done, sat, hist_valid, hist_ready, hist_last;
  logic [B-1:0]  hist_bin;
  logic [WC-1:0] hist_count;
  logic [SW-1:0] hist_sumsq;

  prng_hist #(.Wout(W), .Bbits(B), .Wcnt(WC), .Nsamp(N)) dut (
    .clk(clk), .rst(rst), .din(din), .start(start), .busy(busy), .done(done),
    .sat(sat), .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
    .hist_count(hist_count), .hist_last(hist_last), .hist_sumsq(hist_sumsq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int cnt;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_sat;
  int   exp_sq;
  bit   run_done;
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares each handshaken word, output hold under stall, and the done cycle.
  bit            stalled = 0;
  bit            pend    = 0;
  logic [B-1:0]  hb;
  logic [WC-1:0] hc;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
      pend    = 0;
    end else begin
      if (pend) begin
        check("done_pulse", {done, busy}, 2'b10);
        check("sat_at_done", sat, exp_sat);
        check("sumsq_at_done", hist_sumsq, CHI ? exp_sq : 0);
        pend     = 0;
        run_done = 1;
      end else if (done) begin
        check("done_spurious", done, 0);
      end
      if (hist_valid) begin
        if (stalled) check("stall_hold", {hist_bin, hist_count}, {hb, hc});
        if (hist_ready) begin
          stalled = 0;
          if (exp_q.size() == 0) begin
            check("extra_word", hist_bin, -1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("word_bin",   hist_bin,   e.bin);
            check("word_count", hist_count, e.cnt);
            check("word_last",  hist_last,  e.last);
            if (e.last) pend = 1;
          end
        end else begin
          stalled = 1;
          hb = hist_bin;
          hc = hist_count;
        end
      end
    end
  end

  // mode: 0 random bins, 1 constant bin cbin, 2 repeating pairs 0,0,1,1,...
  // rmode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
  task automatic run(input int mode, input int cbin, input int rmode, input bit poke, input int rst_at);
    int       stream[N];
    int       raw[NB];
    int       j;
    for (int b = 0; b < NB; b++) raw[b] = 0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       stream[i] = $urandom_range(NB-1);
        1:       stream[i] = cbin;
        default: stream[i] = (i / 2) % NB;
      endcase
      raw[stream[i]]++;
    end
    exp_sat = 0;
    exp_sq  = 0;
    for (int b = 0; b < NB; b++) begin
      exp_t e;
      e.bin  = b;
      e.cnt  = (raw[b] > CMAX) ? CMAX : raw[b];
      e.last = (b == NB-1);
      if (raw[b] > CMAX) exp_sat = 1;
      exp_sq += e.cnt * e.cnt;
      exp_q.push_back(e);
    end
    run_done = 0;

    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    check("sat_cleared_on_start", sat, 0);
    check("sumsq_cleared_on_start", hist_sumsq, 0);

    for (int cyc = 1; cyc < NB + N + 120 && !run_done; cyc++) begin
      j   = cyc - NB - 1;
      din = $urandom;
      if (j >= 0 && j < N) din[W-1 -: B] = B'(stream[j]);
      case (rmode)
        0:       hist_ready = 1;
        1:       hist_ready = (cyc % 3 == 0);
        default: hist_ready = $urandom_range(1);
      endcase
      start = poke && (cyc == NB + 3 || cyc == NB + N + 4);
      if (cyc == rst_at) begin
        start = 0;
        #2 rst = 1;
        #1;
        check("rst_mid_busy",  busy, 0);
        check("rst_mid_valid", hist_valid, 0);
        check("rst_mid_done",  done, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      @(posedge clk); #1;
    end
    start = 0;
    if (!run_done) check("run_timeout", 0, 1);
    check("words_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1;
    start = 0;
    din = '0;
    hist_ready = 0;
    #8;
    check("reset_busy",  busy, 0);
    check("reset_done",  done, 0);
    check("reset_sat",   sat, 0);
    check("reset_valid", hist_valid, 0);
    check("reset_count", hist_count, 0);
    check("reset_sumsq", hist_sumsq, 0);
    @(posedge clk); #1;
    rst = 0;

    run(0, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0);
    run(1, 5, 1, 0, 0);
    run(0, 0, 2, 0, 0);
    run(0, 0, 1, 1, 0);
    run(1, 2, 0, 0, NB + 5);
    run(2, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) run($urandom_range(2), $urandom_range(NB-1), $urandom_range(2), 1'($urandom_range(1)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
